// File: rtl/tiny16_bus_pkg.sv
// Shared definitions for tiny16 bus responders: register map, CTRL/STATUS
// bit positions, access FSM states and wait-state counter width.
package tiny16_bus_pkg;

    localparam int unsigned WAIT_W = 4;
    typedef logic [WAIT_W-1:0] wait_cnt_t;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_WAIT = 2'd1,
        ACC_DONE = 2'd2
    } acc_state_t;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_idx_t;

    localparam int unsigned CTRL_ENABLE       = 0;
    localparam int unsigned CTRL_AUTO_RELOAD  = 1;
    localparam int unsigned CTRL_IRQ_EN       = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;
    localparam int unsigned CTRL_PRESCALE_MSB = 15;
    localparam int unsigned STATUS_EXPIRED    = 0;

    // A responder owns a 4-word window; the two low address bits pick the word.
    function automatic logic window_hit(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:2] == base[15:2];
    endfunction

endpackage

// File: rtl/tiny16_timer_if.sv
// tiny16 CPU bus as seen by one responder, plus its interrupt line.
interface tiny16_timer_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rd;
    logic        wr;
    logic        ready;
    logic        interrupt;

    modport master (
        output address, data_in, rd, wr,
        input  data_out, ready, interrupt
    );

    modport slave (
        input  address, data_in, rd, wr,
        output data_out, ready, interrupt
    );
endinterface

// File: rtl/tiny16_bus_wait.sv
// Access sequencer for a tiny16 bus responder: inserts WAIT_STATES wait
// cycles via ready and emits a single-cycle commit on the completing edge.
module tiny16_bus_wait
    import tiny16_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acc,
    input  logic [15:0] address,
    output logic        ready,
    output logic        commit
);
    localparam wait_cnt_t WS = wait_cnt_t'(WAIT_STATES);

    acc_state_t  state, state_nxt;
    wait_cnt_t   cnt, cnt_nxt;
    logic [15:0] addr_q, addr_nxt;
    logic        start;

    // A new access begins from IDLE, or from DONE when the address moved on.
    assign start = acc & ((state == ACC_IDLE) | ((state == ACC_DONE) & (address != addr_q)));

    // State register, wait counter and latched access address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ACC_IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        case (state)
            ACC_IDLE, ACC_DONE: begin
                if (start) begin
                    addr_nxt = address;
                    if (WS == '0) begin
                        state_nxt = ACC_DONE;
                    end else begin
                        cnt_nxt   = WS - wait_cnt_t'(1);
                        state_nxt = ACC_WAIT;
                    end
                end else if (!acc) begin
                    state_nxt = ACC_IDLE;
                end
            end
            ACC_WAIT: begin
                if (!acc) begin
                    state_nxt = ACC_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = ACC_DONE;
                end else begin
                    cnt_nxt = cnt - wait_cnt_t'(1);
                end
            end
            default: state_nxt = ACC_IDLE;
        endcase
    end

    // Outputs: ready stalls only a live access; commit marks the completing cycle.
    always_comb begin
        ready  = 1'b1;
        commit = 1'b0;
        case (state)
            ACC_IDLE: begin
                ready  = !(acc && (WS != '0));
                commit = acc && (WS == '0);
            end
            ACC_WAIT: begin
                ready  = !(acc && (cnt != '0));
                commit = acc && (cnt == '0);
            end
            ACC_DONE: begin
                commit = start && (WS == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tiny16_timer.sv
// Memory-mapped 16-bit interval timer on the tiny16 bus: CTRL, RELOAD,
// COUNT and STATUS registers, prescaled tick, level interrupt on expiry.
module tiny16_timer
    import tiny16_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDRESS = 16'hFF00,
    parameter int unsigned WAIT_STATES  = 1
) (
    input logic           clk,
    input logic           reset,
    tiny16_timer_if.slave bus
);
    logic        sel;
    logic        acc;
    logic        commit;
    logic        we;
    reg_idx_t    reg_idx;
    logic        wr_ctrl, wr_reload, wr_count, wr_status;

    logic        ctrl_enable;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic [7:0]  ctrl_prescale;
    logic [7:0]  pre;
    logic [15:0] reload_q;
    logic [15:0] count_q;
    logic        expired;
    logic        tick;
    logic        expire;

    // Address decode and per-register write strobes for the committing access.
    always_comb begin
        sel       = window_hit(bus.address, BASE_ADDRESS);
        acc       = sel & (~bus.rd | ~bus.wr);
        reg_idx   = reg_idx_t'(bus.address[1:0]);
        we        = commit & ~bus.wr;
        wr_ctrl   = we & (reg_idx == REG_CTRL);
        wr_reload = we & (reg_idx == REG_RELOAD);
        wr_count  = we & (reg_idx == REG_COUNT);
        wr_status = we & (reg_idx == REG_STATUS);
    end

    tiny16_bus_wait #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .acc     (acc),
        .address (bus.address),
        .ready   (bus.ready),
        .commit  (commit)
    );

    // Tick when the running prescaler hits zero; expiry is a tick at COUNT zero.
    always_comb begin
        tick   = ctrl_enable & (pre == '0);
        expire = tick & (count_q == '0);
    end

    // CTRL register; a bus write overrides the one-shot enable clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_enable      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_prescale    <= '0;
        end else if (wr_ctrl) begin
            ctrl_enable      <= bus.data_in[CTRL_ENABLE];
            ctrl_auto_reload <= bus.data_in[CTRL_AUTO_RELOAD];
            ctrl_irq_en      <= bus.data_in[CTRL_IRQ_EN];
            ctrl_prescale    <= bus.data_in[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        end else if (expire && !ctrl_auto_reload) begin
            ctrl_enable <= 1'b0;
        end
    end

    // Prescaler: restarts from the newly written prescale when enable rises.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre <= '0;
        end else if (wr_ctrl && bus.data_in[CTRL_ENABLE] && !ctrl_enable) begin
            pre <= bus.data_in[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        end else if (ctrl_enable) begin
            pre <= (pre == '0) ? ctrl_prescale : pre - 8'd1;
        end
    end

    // RELOAD register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (wr_reload) begin
            reload_q <= bus.data_in;
        end
    end

    // COUNT register; a bus write takes priority over a tick on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= bus.data_in;
        end else if (tick) begin
            if (count_q != '0) begin
                count_q <= count_q - 16'd1;
            end else if (ctrl_auto_reload) begin
                count_q <= reload_q;
            end
        end
    end

    // STATUS.expired: write-1-to-clear, but a simultaneous expiry keeps it set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && bus.data_in[STATUS_EXPIRED]) begin
            expired <= 1'b0;
        end
    end

    // Read mux; drives zero when the window is not selected so it can be OR-combined.
    always_comb begin
        bus.data_out = '0;
        if (sel) begin
            case (reg_idx)
                REG_CTRL: begin
                    bus.data_out[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = ctrl_prescale;
                    bus.data_out[CTRL_IRQ_EN]      = ctrl_irq_en;
                    bus.data_out[CTRL_AUTO_RELOAD] = ctrl_auto_reload;
                    bus.data_out[CTRL_ENABLE]      = ctrl_enable;
                end
                REG_RELOAD: bus.data_out = reload_q;
                REG_COUNT:  bus.data_out = count_q;
                REG_STATUS: bus.data_out[STATUS_EXPIRED] = expired;
                default: ;
            endcase
        end
    end

    // Level interrupt derived from registered state only.
    always_comb begin
        bus.interrupt = expired & ctrl_irq_en;
    end

endmodule

// File: tb/tb_tiny16_timer.sv
// Self-checking bench for tiny16_timer: directed scenarios followed by
// random bus traffic, all compared against a behavioural timer model.
module tb_tiny16_timer;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] PARK = 16'hFF02;
    localparam int WS1 = 1;
    localparam int WS3 = 3;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset3 = 1'b0;
    logic reset0 = 1'b0;

    int total = 0;
    int bad   = 0;

    // behavioural model of the WS1 instance
    int m_en, m_ar, m_ie, m_ps, m_pre, m_reload, m_count, m_exp;

    always #5 clk = ~clk;

    tiny16_timer_if bus1();
    tiny16_timer_if bus3();
    tiny16_timer_if bus0();

    tiny16_timer #(.BASE_ADDRESS(BASE), .WAIT_STATES(WS1)) dut  (.clk(clk), .reset(reset),  .bus(bus1));
    tiny16_timer #(.BASE_ADDRESS(BASE), .WAIT_STATES(WS3)) dut3 (.clk(clk), .reset(reset3), .bus(bus3));
    tiny16_timer #(.BASE_ADDRESS(BASE), .WAIT_STATES(0))   dut0 (.clk(clk), .reset(reset0), .bus(bus0));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int idx);
        case (idx)
            0:       return 16'((m_ps << 8) | (m_ie << 2) | (m_ar << 1) | m_en);
            1:       return 16'(m_reload);
            2:       return 16'(m_count);
            default: return 16'(m_exp);
        endcase
    endfunction

    // One clock edge of the timer, with an optional bus write landing on it.
    task automatic model_edge(input bit w, input int idx, input int d);
        bit tk, ex;
        int n_en, n_ar, n_ie, n_ps, n_pre, n_count, n_exp, n_reload;
        tk = (m_en != 0) && (m_pre == 0);
        ex = tk && (m_count == 0);
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_ps = m_ps; n_pre = m_pre;
        n_count = m_count; n_exp = m_exp; n_reload = m_reload;
        if (m_en != 0) n_pre = tk ? m_ps : m_pre - 1;
        if (tk && m_count != 0) n_count = m_count - 1;
        if (ex) begin
            n_exp = 1;
            if (m_ar != 0) n_count = m_reload;
            else n_en = 0;
        end
        if (w) begin
            case (idx)
                0: begin
                    n_en = d & 1;
                    n_ar = (d >> 1) & 1;
                    n_ie = (d >> 2) & 1;
                    n_ps = (d >> 8) & 255;
                    if (n_en != 0 && m_en == 0) n_pre = n_ps;
                end
                1: n_reload = d & 16'hFFFF;
                2: n_count = d & 16'hFFFF;
                default: if ((d & 1) != 0 && !ex) n_exp = 0;
            endcase
        end
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_ps = n_ps; m_pre = n_pre;
        m_count = n_count; m_exp = n_exp; m_reload = n_reload;
    endtask

    task automatic clk_edge(input bit w, input int idx, input int d);
        @(posedge clk);
        model_edge(w, idx, d);
        #1;
    endtask

    // Idle cycles with the address parked on COUNT (selected, no access).
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            clk_edge(1'b0, 0, 0);
            #1;
            chk("idle_count", bus1.data_out, 16'(m_count));
            chk("idle_irq", {15'd0, bus1.interrupt}, 16'(m_exp & m_ie));
            chk("idle_ready", {15'd0, bus1.ready}, 16'h0001);
        end
    endtask

    task automatic bus_write(input int idx, input int d, input int hold);
        bus1.address = BASE | 16'(idx);
        bus1.data_in = 16'(d);
        bus1.wr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("wr_ready", {15'd0, bus1.ready}, (i < WS1) ? 16'h0000 : 16'h0001);
            chk("wr_view", bus1.data_out, model_read(idx));
            clk_edge(i == WS1, idx, d);
        end
        bus1.wr = 1'b1;
        bus1.address = PARK;
        idle(1);
    endtask

    task automatic bus_read(input int idx);
        bus1.address = BASE | 16'(idx);
        bus1.rd = 1'b0;
        for (int i = 0; i <= WS1; i++) begin
            #1;
            chk("rd_ready", {15'd0, bus1.ready}, (i < WS1) ? 16'h0000 : 16'h0001);
            if (i == WS1) chk("rd_data", bus1.data_out, model_read(idx));
            clk_edge(1'b0, 0, 0);
        end
        bus1.rd = 1'b1;
        bus1.address = PARK;
        idle(1);
    endtask

    initial begin
        int op, idx, d;
        bus1.address = 16'h0000; bus1.data_in = 16'h0000; bus1.rd = 1'b1; bus1.wr = 1'b1;
        bus3.address = 16'h0000; bus3.data_in = 16'h0000; bus3.rd = 1'b1; bus3.wr = 1'b1;
        bus0.address = 16'h0000; bus0.data_in = 16'h0000; bus0.rd = 1'b1; bus0.wr = 1'b1;
        m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0; m_pre = 0; m_reload = 0; m_count = 0; m_exp = 0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; reset3 = 1'b1; reset0 = 1'b1;
        #1;
        chk("rst_ready", {15'd0, bus1.ready}, 16'h0001);
        chk("rst_irq", {15'd0, bus1.interrupt}, 16'h0000);
        chk("rst_dout", bus1.data_out, 16'h0000);
        chk("rst_ready3", {15'd0, bus3.ready}, 16'h0001);

        // all registers read back zero, one wait cycle each
        for (int r = 0; r < 4; r++) bus_read(r);

        // unselected address
        bus1.address = 16'hFFF0; bus1.rd = 1'b0;
        #1;
        chk("unsel_dout", bus1.data_out, 16'h0000);
        chk("unsel_ready", {15'd0, bus1.ready}, 16'h0001);
        clk_edge(1'b0, 0, 0);
        bus1.rd = 1'b1; bus1.address = PARK;
        idle(1);

        // auto-reload run with prescale 1
        bus_write(1, 3, 2);
        bus_write(0, 16'h0107, 2);
        idle(1);
        chk("first_reload", bus1.data_out, 16'h0003);
        chk("first_irq", {15'd0, bus1.interrupt}, 16'h0001);
        idle(10);

        // held write strobes commit once
        bus_write(2, 5, 5);
        bus_write(0, 16'h0002, 5);
        idle(6);
        bus_read(0);

        // STATUS clear colliding with a fresh expiry
        bus_write(3, 1, 2);
        bus_write(2, 2, 2);
        bus_write(1, 3, 2);
        bus_write(0, 16'h0007, 2);
        bus_write(3, 1, 2);
        chk("collide_irq", {15'd0, bus1.interrupt}, 16'h0001);
        bus_write(0, 16'h0004, 2);
        bus_write(3, 1, 2);
        chk("clear_irq", {15'd0, bus1.interrupt}, 16'h0000);

        // COUNT write on a tick edge, then one-shot expiry without reload
        bus_write(2, 3, 2);
        bus_write(0, 16'h0001, 2);
        bus_write(2, 16'h0010, 2);
        chk("count_wins", bus1.data_out, 16'h000F);
        idle(18);
        chk("noar_count", bus1.data_out, 16'h0000);
        bus_read(0);
        bus_read(3);

        // CTRL write colliding with the expiry-driven enable clear
        bus_write(2, 2, 2);
        bus_write(0, 16'h0001, 2);
        bus_write(0, 16'h0001, 3);
        idle(3);

        // random traffic
        for (int r = 0; r < 80; r++) begin
            op  = $urandom_range(0, 3);
            idx = $urandom_range(0, 3);
            case (idx)
                0:       d = int'($urandom & 32'h0307);
                1, 2:    d = $urandom_range(0, 5);
                default: d = int'($urandom & 32'h1);
            endcase
            if (op == 0) bus_read(idx);
            else if (op == 1) idle($urandom_range(1, 4));
            else bus_write(idx, d, $urandom_range(2, 4));
        end

        // three wait states: ready low 3 cycles, commit on edge 4
        bus3.address = BASE | 16'd2; bus3.data_in = 16'h1234; bus3.wr = 1'b0;
        for (int i = 0; i <= WS3; i++) begin
            #1;
            chk("ws3_ready", {15'd0, bus3.ready}, (i < WS3) ? 16'h0000 : 16'h0001);
            chk("ws3_pre", bus3.data_out, 16'h0000);
            @(posedge clk); #1;
        end
        #1;
        chk("ws3_commit", bus3.data_out, 16'h1234);
        bus3.wr = 1'b1;
        @(posedge clk); #1;

        // reset in the middle of a waited write drops it
        bus3.data_in = 16'h0055; bus3.wr = 1'b0;
        #1;
        chk("rst3_ready0", {15'd0, bus3.ready}, 16'h0000);
        @(posedge clk); #1;
        chk("rst3_ready1", {15'd0, bus3.ready}, 16'h0000);
        @(posedge clk); #1;
        chk("rst3_ready2", {15'd0, bus3.ready}, 16'h0000);
        reset3 = 1'b0;
        @(posedge clk); #1;
        bus3.wr = 1'b1; reset3 = 1'b1;
        #1;
        chk("rst3_ready", {15'd0, bus3.ready}, 16'h0001);
        chk("rst3_count", bus3.data_out, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("rst3_hold", bus3.data_out, 16'h0000);
        end

        // zero wait states: ready never drops, commit on the first edge
        bus0.address = BASE | 16'd2; bus0.data_in = 16'h00AB; bus0.wr = 1'b0;
        #1;
        chk("ws0_ready", {15'd0, bus0.ready}, 16'h0001);
        chk("ws0_pre", bus0.data_out, 16'h0000);
        @(posedge clk); #1;
        chk("ws0_commit", bus0.data_out, 16'h00AB);
        bus0.wr = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
